lfsr_cipher_engine: RTL and testbench
=====================================

LFSR_CIPHER_ENGINE -- requirements
Module: lfsr_cipher_engine

Interface
REQ-001 Parameter SRC_BASE, default 8'd0, first source (plaintext) byte address.
REQ-002 Parameter DST_BASE, default 8'd64, first destination (ciphertext) byte address.
REQ-003 Parameter LEN, default 64, bytes processed per run, 1..64; SRC_BASE+LEN and DST_BASE+LEN SHALL each be <= 256.
REQ-004 Parameter TAP_BASE, default 8'd130, address of tap-pattern entry 0; entries 0..8 are valid.
REQ-005 Clk  input  1  single clock, all state updates on posedge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Start  input  1  request one run; sampled only in IDLE.
REQ-008 TapSel  input  4  tap-pattern index, sampled with Start.
REQ-009 Seed  input  7  LFSR initial state, sampled with Start.
REQ-010 DataAddress  output  8  memory address driven to the data memory.
REQ-011 WriteEn  output  1  memory write strobe.
REQ-012 DataOut  output  8  write data to memory.
REQ-013 DataIn  input  8  memory read data, combinational from DataAddress, same cycle.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 Done  output  1  one-cycle completion pulse.
REQ-016 Err  output  1  status of the last run; held until the next accepted Start.

Function
REQ-017 States: IDLE, TAP, RD, WR, FIN; IDLE->TAP when Start=1, latching TapSel, Seed; Err cleared.
REQ-018 TAP: DataAddress=TAP_BASE+TapSel; tap register <= DataIn[6:0]; LFSR <= Seed, or 7'h01 if Seed==0; index i <= 0; next RD.
REQ-019 TAP with latched TapSel>8: no memory access, no tap load; Err <= 1; next FIN; no write SHALL occur during that run.
REQ-020 RD: DataAddress=SRC_BASE+i; data register <= DataIn; next WR.
REQ-021 WR: DataAddress=DST_BASE+i; WriteEn=1; DataOut={data[7], data[6:0]^LFSR}.
REQ-022 On leaving WR: LFSR <= {LFSR[5:0], ^(LFSR & tap)}; i <= i+1; next RD if i<LEN-1, else FIN.
REQ-023 FIN: Done=1 for exactly one cycle; next IDLE.
REQ-024 WriteEn SHALL be 0 in every state except WR; DataOut=0 and DataAddress=0 in IDLE and FIN.
REQ-025 Latency: with Start sampled at edge 0, Done SHALL be high in the cycle after edge 2*LEN+1 (error run: after edge 1).
REQ-026 Start while Busy=1 SHALL be ignored; Start held high at FIN->IDLE SHALL begin a new run on the next edge.
REQ-027 Index i SHALL be 6 bits; address sums SHALL be 8-bit with no wrap within legal parameters.

Reset
REQ-028 On Reset at any edge, including mid-run: state=IDLE, Busy=0, Done=0, Err=0, WriteEn=0, LFSR=0, tap=0, i=0; Reset dominates Start in the same cycle.
REQ-029 No partial write SHALL occur in the cycle following a Reset edge.

Structure
REQ-030 Package cipher_pkg SHALL hold the state enum, TAP_BASE default, and max tap index constant (8).
REQ-031 Sub-module lfsr7_step SHALL compute the combinational next state from (state, tap).
REQ-032 All control outputs SHALL be decoded from registered state; no combinational path from Start to WriteEn.

Verification
REQ-033 Memory src[0]=0x41, src[1]=0x41, Core[130]=0x60, TapSel=0, Seed=0x01 -> dst[64]=0x40, dst[65]=0x43.
REQ-034 LEN=64 full run -> WriteEn high for exactly 64 cycles, Done high at cycle 130 after Start edge, Busy low afterward.
REQ-035 TapSel=9 -> Err=1, Done at cycle 2, zero WriteEn cycles, memory unchanged.
REQ-036 Seed=0 with tap 0x60 -> first LFSR value used = 0x01, matching the Seed=0x01 result.
REQ-037 Reset asserted during RD of byte 10 -> next cycle IDLE, WriteEn=0, bytes 10..63 of dst untouched; new Start completes normally.
REQ-038 Start pulsed while Busy -> no restart, single Done pulse at the original expected cycle.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and constants for the LFSR byte cipher engine.
package cipher_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAP,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [7:0] TAP_BASE_DEF = 8'd130;
    localparam logic [3:0] MAX_TAP_IDX  = 4'd8;

endpackage

// File: rtl/lfsr7_step.sv
// One Fibonacci step of a 7-bit LFSR: shift left, feedback is parity of tapped bits.
module lfsr7_step (
    input  logic [6:0] state,
    input  logic [6:0] tap,
    output logic [6:0] next_state
);

    assign next_state = {state[5:0], ^(state & tap)};

endmodule

// File: rtl/lfsr_cipher_engine.sv
// Reads LEN plaintext bytes, XORs the low 7 bits with an LFSR keystream and
// writes ciphertext back to memory; tap pattern is fetched from a memory table.
module lfsr_cipher_engine
    import cipher_pkg::*;
#(
    parameter logic [7:0] SRC_BASE = 8'd0,
    parameter logic [7:0] DST_BASE = 8'd64,
    parameter int         LEN      = 64,
    parameter logic [7:0] TAP_BASE = TAP_BASE_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] TapSel,
    input  logic [6:0] Seed,
    output logic [7:0] DataAddress,
    output logic       WriteEn,
    output logic [7:0] DataOut,
    input  logic [7:0] DataIn,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    localparam logic [5:0] LAST_IDX = 6'(LEN - 1);

    state_t      state, state_nxt;
    logic [3:0]  tapsel_q;
    logic [6:0]  seed_q;
    logic [6:0]  tap_q;
    logic [6:0]  lfsr_q;
    logic [6:0]  lfsr_nxt;
    logic [5:0]  idx_q;
    logic [7:0]  data_q;
    logic        err_q;
    logic        tap_ok;
    logic        last;

    assign tap_ok = (tapsel_q <= MAX_TAP_IDX);
    assign last   = (idx_q == LAST_IDX);

    lfsr7_step u_step (
        .state      (lfsr_q),
        .tap        (tap_q),
        .next_state (lfsr_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_TAP;
            S_TAP:   state_nxt = tap_ok ? S_RD : S_FIN;
            S_RD:    state_nxt = S_WR;
            S_WR:    state_nxt = last ? S_FIN : S_RD;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory-side outputs depend on registered state only, never on Start.
    always_comb begin
        DataAddress = 8'd0;
        WriteEn     = 1'b0;
        DataOut     = 8'd0;
        case (state)
            S_TAP: if (tap_ok) DataAddress = TAP_BASE + {4'd0, tapsel_q};
            S_RD:  DataAddress = SRC_BASE + {2'd0, idx_q};
            S_WR: begin
                DataAddress = DST_BASE + {2'd0, idx_q};
                WriteEn     = 1'b1;
                DataOut     = {data_q[7], data_q[6:0] ^ lfsr_q};
            end
            default: ;
        endcase
    end

    assign Busy = (state != S_IDLE);
    assign Done = (state == S_FIN);
    assign Err  = err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            tapsel_q <= 4'd0;
            seed_q   <= 7'd0;
            tap_q    <= 7'd0;
            lfsr_q   <= 7'd0;
            idx_q    <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (Start) begin
                    tapsel_q <= TapSel;
                    seed_q   <= Seed;
                    err_q    <= 1'b0;
                end
                S_TAP: if (tap_ok) begin
                    tap_q  <= DataIn[6:0];
                    // An all-zero seed would lock the LFSR, so substitute 1.
                    lfsr_q <= (seed_q == 7'd0) ? 7'h01 : seed_q;
                    idx_q  <= 6'd0;
                end else begin
                    err_q <= 1'b1;
                end
                S_WR: begin
                    lfsr_q <= lfsr_nxt;
                    idx_q  <= idx_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (state == S_RD) data_q <= DataIn;
    end

endmodule

// File: tb/tb_lfsr_cipher_engine.sv
// Self-checking bench for lfsr_cipher_engine: table-driven runs plus corner sequences.
module tb_lfsr_cipher_engine;

    localparam int         LEN = 64;
    localparam logic [7:0] SRC = 8'd0;
    localparam logic [7:0] DST = 8'd64;
    localparam logic [7:0] TBA = 8'd130;

    logic       Clk = 1'b0;
    logic       Reset, Start;
    logic [3:0] TapSel;
    logic [6:0] Seed;
    logic [7:0] DataAddress, DataOut, DataIn;
    logic       WriteEn, Busy, Done, Err;

    logic [7:0] rom [256];
    logic [7:0] dst [256];
    logic       clr_dst;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sbq[$];

    typedef struct {
        logic [3:0] ts;
        logic [6:0] sd;
        bit         exp_err;
        bit         chk_first;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t vecs [7];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    lfsr_cipher_engine #(
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .LEN      (LEN),
        .TAP_BASE (TBA)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .TapSel      (TapSel),
        .Seed        (Seed),
        .DataAddress (DataAddress),
        .WriteEn     (WriteEn),
        .DataOut     (DataOut),
        .DataIn      (DataIn),
        .Busy        (Busy),
        .Done        (Done),
        .Err         (Err)
    );

    assign DataIn = rom[DataAddress];

    always @(posedge Clk) begin
        if (clr_dst) begin
            for (int j = 0; j < 256; j++) dst[j] <= 8'd0;
        end else if (WriteEn) begin
            dst[DataAddress] <= DataOut;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_expect(input logic [3:0] ts, input logic [6:0] sd);
        logic [6:0] l, tp;
        logic [7:0] d;
        wr_t w;
        l  = (sd == 7'd0) ? 7'h01 : sd;
        tp = rom[TBA + 8'(ts)][6:0];
        for (int k = 0; k < LEN; k++) begin
            d      = rom[SRC + 8'(k)];
            w.addr = DST + 8'(k);
            w.data = {d[7], d[6:0] ^ l};
            sbq.push_back(w);
            l = {l[5:0], ^(l & tp)};
        end
    endtask

    task automatic clear_dst();
        @(negedge Clk); clr_dst = 1'b1;
        @(negedge Clk); clr_dst = 1'b0;
    endtask

    // Entered just after the edge that sampled Start; e counts edges since then.
    task automatic wait_done(input int pulse_at, input bit hold, input int abort_at,
                             output int done_edge, output int wr_seen);
        int  e;
        wr_t w;
        done_edge = -1;
        wr_seen   = 0;
        e         = 0;
        while (e < 400) begin
            @(negedge Clk);
            if (WriteEn) begin
                wr_seen++;
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = sbq.pop_front();
                    chk($sformatf("wr_addr[%0d]", wr_seen - 1), int'(DataAddress), int'(w.addr));
                    chk($sformatf("wr_data[%0d]", wr_seen - 1), int'(DataOut), int'(w.data));
                end
            end
            if (Done) begin
                done_edge = e;
                break;
            end
            if (e == abort_at) break;
            if (!hold) Start = (e == pulse_at);
            @(posedge Clk);
            e++;
        end
    endtask

    task automatic run_full(input string name, input logic [3:0] ts, input logic [6:0] sd,
                            input int pulse_at, input bit exp_err);
        int de, ws;
        if (!exp_err) push_expect(ts, sd);
        @(negedge Clk);
        TapSel = ts;
        Seed   = sd;
        Start  = 1'b1;
        @(posedge Clk);
        wait_done(pulse_at, 1'b0, -1, de, ws);
        Start = 1'b0;
        chk({name, "_done_edge"}, de, exp_err ? 1 : 2 * LEN + 1);
        chk({name, "_writes"}, ws, exp_err ? 0 : LEN);
        chk({name, "_err"}, int'(Err), int'(exp_err));
        chk({name, "_sb_left"}, sbq.size(), 0);
        @(posedge Clk);
        @(negedge Clk);
        chk({name, "_busy_after"}, int'(Busy), 0);
        chk({name, "_done_single"}, int'(Done), 0);
        chk({name, "_err_held"}, int'(Err), int'(exp_err));
        sbq.delete();
    endtask

    initial begin
        int de, ws, nz;

        Reset = 1'b1; Start = 1'b0; TapSel = 4'd0; Seed = 7'd0; clr_dst = 1'b0;
        for (int j = 0; j < 256; j++) rom[j] = 8'(j * 37 + 11);
        rom[0] = 8'h41;
        rom[1] = 8'h41;
        rom[130] = 8'h60; rom[131] = 8'h03; rom[132] = 8'h41; rom[133] = 8'h7F;
        rom[134] = 8'h11; rom[135] = 8'h28; rom[136] = 8'h66; rom[137] = 8'h0C;
        rom[138] = 8'h44;

        vecs[0] = '{ts: 4'd0,  sd: 7'h01, exp_err: 1'b0, chk_first: 1'b1, b0: 8'h40, b1: 8'h43};
        vecs[1] = '{ts: 4'd0,  sd: 7'h00, exp_err: 1'b0, chk_first: 1'b1, b0: 8'h40, b1: 8'h43};
        vecs[2] = '{ts: 4'd3,  sd: 7'h5A, exp_err: 1'b0, chk_first: 1'b0, b0: 8'h00, b1: 8'h00};
        vecs[3] = '{ts: 4'd8,  sd: 7'h7F, exp_err: 1'b0, chk_first: 1'b0, b0: 8'h00, b1: 8'h00};
        vecs[4] = '{ts: 4'd9,  sd: 7'h22, exp_err: 1'b1, chk_first: 1'b0, b0: 8'h00, b1: 8'h00};
        vecs[5] = '{ts: 4'd5,  sd: 7'h33, exp_err: 1'b0, chk_first: 1'b0, b0: 8'h00, b1: 8'h00};
        vecs[6] = '{ts: 4'd15, sd: 7'h11, exp_err: 1'b1, chk_first: 1'b0, b0: 8'h00, b1: 8'h00};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_err", int'(Err), 0);
        chk("rst_we", int'(WriteEn), 0);
        chk("rst_addr", int'(DataAddress), 0);
        chk("rst_dout", int'(DataOut), 0);
        Reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            clear_dst();
            run_full($sformatf("vec%0d", v), vecs[v].ts, vecs[v].sd, -1, vecs[v].exp_err);
            if (vecs[v].chk_first) begin
                chk($sformatf("vec%0d_dst64", v), int'(dst[DST]), int'(vecs[v].b0));
                chk($sformatf("vec%0d_dst65", v), int'(dst[DST + 8'd1]), int'(vecs[v].b1));
            end
            if (vecs[v].exp_err) begin
                nz = 0;
                for (int j = 0; j < 256; j++) if (dst[j] != 8'd0) nz++;
                chk($sformatf("vec%0d_mem_untouched", v), nz, 0);
            end
        end

        // Err held from the failed run; Reset together with Start clears it and wins.
        chk("err_held_idle", int'(Err), 1);
        @(negedge Clk); Reset = 1'b1; Start = 1'b1; TapSel = 4'd0; Seed = 7'h01;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_vs_start_busy", int'(Busy), 0);
        chk("rst_clears_err", int'(Err), 0);
        Reset = 1'b0; Start = 1'b0;

        // Reset while reading byte 10.
        clear_dst();
        push_expect(4'd2, 7'h15);
        @(negedge Clk); TapSel = 4'd2; Seed = 7'h15; Start = 1'b1;
        @(posedge Clk);
        wait_done(-1, 1'b0, 21, de, ws);
        chk("midrst_in_rd_addr", int'(DataAddress), int'(SRC) + 10);
        chk("midrst_in_rd_we", int'(WriteEn), 0);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_we", int'(WriteEn), 0);
        chk("midrst_done", int'(Done), 0);
        chk("midrst_addr", int'(DataAddress), 0);
        chk("midrst_writes", ws, 10);
        Reset = 1'b0;
        sbq.delete();
        nz = 0;
        for (int j = 10; j < LEN; j++) if (dst[DST + 8'(j)] != 8'd0) nz++;
        chk("midrst_tail_untouched", nz, 0);
        run_full("after_rst", 4'd0, 7'h01, -1, 1'b0);

        // Start pulsed mid-run must not restart.
        clear_dst();
        run_full("busy_start", 4'd4, 7'h2B, 40, 1'b0);

        // Start held high through FIN begins a second run straight away.
        clear_dst();
        push_expect(4'd6, 7'h19);
        @(negedge Clk); TapSel = 4'd6; Seed = 7'h19; Start = 1'b1;
        @(posedge Clk);
        wait_done(-1, 1'b1, -1, de, ws);
        chk("hold_done_edge", de, 2 * LEN + 1);
        chk("hold_writes", ws, LEN);
        @(posedge Clk);
        @(negedge Clk);
        chk("hold_idle_busy", int'(Busy), 0);
        push_expect(4'd6, 7'h19);
        @(posedge Clk);
        wait_done(-1, 1'b0, -1, de, ws);
        Start = 1'b0;
        chk("hold_run2_done_edge", de, 2 * LEN + 1);
        chk("hold_run2_writes", ws, LEN);
        @(posedge Clk);
        @(negedge Clk);
        chk("hold_run2_busy_after", int'(Busy), 0);
        sbq.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
